// File: rtl/bimodal_predictor.sv
// -----------------------------------------------------------------------------
// bimodal_predictor
//   Branch direction predictor placed after the SPI receiver. Each accepted
//   request looks up a 2-bit saturating counter chosen by gshare indexing
//   (low address bits XOR global history), reports the predicted direction,
//   then trains the counter with the real outcome and keeps hit statistics.
//
// Ports
//   clk                     in   system clock, posedge
//   rst                     in   asynchronous, active-high reset
//   data_input_done         in   1-cycle pulse: inst_addr / truth are valid
//   inst_addr               in   branch instruction address
//   direction_ground_truth  in   actual branch outcome (1 = taken)
//   prediction              out  predicted direction, held until next lookup
//   prediction_valid        out  1-cycle pulse when prediction is refreshed
//   mispredict              out  prediction != truth, held with prediction
//   busy                    out  a request is in flight
//   dropped                 out  sticky: a request arrived while busy
//   correct_count           out  number of correct predictions (saturating)
//   total_count             out  number of predictions made (saturating)
// -----------------------------------------------------------------------------
module bimodal_predictor #(
    parameter int NUM_BITS_OF_INST_ADDR_LATCHED_IN = 16,
    parameter int INDEX_BITS                       = 4,
    parameter int GHR_BITS                         = 4,
    parameter int STAT_BITS                        = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        data_input_done,
    input  logic [NUM_BITS_OF_INST_ADDR_LATCHED_IN-1:0] inst_addr,
    input  logic                                        direction_ground_truth,
    output logic                                        prediction,
    output logic                                        prediction_valid,
    output logic                                        mispredict,
    output logic                                        busy,
    output logic                                        dropped,
    output logic [STAT_BITS-1:0]                        correct_count,
    output logic [STAT_BITS-1:0]                        total_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    // History register keeps at least one bit so the pure-bimodal build
    // still has a legal declaration; it is held at zero in that case.
    localparam int GW      = (GHR_BITS > 0) ? GHR_BITS : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             table_q [ENTRIES];
    logic [INDEX_BITS-1:0]  idx_q, idx_d;
    logic [INDEX_BITS-1:0]  ghr_ext;
    logic                   truth_q, truth_d;
    logic [GW-1:0]          ghr_q, ghr_d;
    logic                   pred_q, pred_d;
    logic                   mis_q, mis_d;
    logic                   valid_q, valid_d;
    logic                   dropped_q, dropped_d;
    logic [STAT_BITS-1:0]   correct_q, correct_d;
    logic [STAT_BITS-1:0]   total_q, total_d;
    logic                   upd_en;
    logic [1:0]             entry_rd, entry_new;

    // History folding and shifting depend on GHR_BITS.
    generate
        if (GHR_BITS == 0) begin : g_no_hist
            assign ghr_ext = '0;
            assign ghr_d   = '0;
        end else if (GHR_BITS == 1) begin : g_hist1
            assign ghr_ext = INDEX_BITS'(ghr_q);
            assign ghr_d   = truth_q;
        end else begin : g_histn
            assign ghr_ext = INDEX_BITS'(ghr_q);
            assign ghr_d   = {ghr_q[GHR_BITS-2:0], truth_q};
        end
    endgenerate

    // Upper address bits are deliberately ignored (aliasing is allowed).
    generate
        if (NUM_BITS_OF_INST_ADDR_LATCHED_IN > INDEX_BITS) begin : g_upper
            logic unused_upper_addr;
            assign unused_upper_addr = ^inst_addr[NUM_BITS_OF_INST_ADDR_LATCHED_IN-1:INDEX_BITS];
        end
    endgenerate

    assign entry_rd = table_q[idx_q];

    // Saturating 2-bit counter step toward the observed outcome.
    always_comb begin
        entry_new = entry_rd;
        if (truth_q && entry_rd != 2'b11) begin
            entry_new = entry_rd + 2'b01;
        end else if (!truth_q && entry_rd != 2'b00) begin
            entry_new = entry_rd - 2'b01;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        truth_d   = truth_q;
        pred_d    = pred_q;
        mis_d     = mis_q;
        valid_d   = 1'b0;
        dropped_d = dropped_q;
        correct_d = correct_q;
        total_d   = total_q;
        upd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_input_done) begin
                    idx_d   = inst_addr[INDEX_BITS-1:0] ^ ghr_ext;
                    truth_d = direction_ground_truth;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                pred_d  = entry_rd[1];
                mis_d   = entry_rd[1] ^ truth_q;
                valid_d = 1'b1;
                state_d = UPDATE;
                if (data_input_done) dropped_d = 1'b1;
            end
            UPDATE: begin
                upd_en  = 1'b1;
                // Both counts freeze together once total saturates.
                if (total_q != '1) begin
                    total_d = total_q + STAT_BITS'(1);
                    if (!mis_q) correct_d = correct_q + STAT_BITS'(1);
                end
                state_d = IDLE;
                if (data_input_done) dropped_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            truth_q   <= 1'b0;
            ghr_q     <= '0;
            pred_q    <= 1'b0;
            mis_q     <= 1'b0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
            correct_q <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            truth_q   <= truth_d;
            pred_q    <= pred_d;
            mis_q     <= mis_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
            correct_q <= correct_d;
            total_q   <= total_d;
            if (upd_en) ghr_q <= ghr_d;
        end
    end

    // NOTE: the counter table is reset because every entry must start
    // weakly not-taken; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
        end else if (upd_en) begin
            table_q[idx_q] <= entry_new;
        end
    end

    assign prediction       = pred_q;
    assign prediction_valid = valid_q;
    assign mispredict       = mis_q;
    assign busy             = (state_q != IDLE);
    assign dropped          = dropped_q;
    assign correct_count    = correct_q;
    assign total_count      = total_q;

endmodule
